// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if
//   Bundles the sequencer's ROM-side and control-unit-side signals.
//   master : the sequencer (drives ROM address/strobe and issued instruction).
//   slave  : environment (drives start/stall and returns ROM read data).
//   Signals:
//     start, stall          control inputs to the sequencer
//     instrData             ROM read data, valid the cycle after instrReadEnable
//     instrAddress          ROM read address (== programCounter)
//     instrReadEnable       ROM read strobe
//     opCode, operand       issued instruction fields
//     instrValid            issued instruction not yet accepted
//     halted                Halt accepted, sequencer stopped
//     programCounter        address of the next instruction to fetch
interface instruction_sequencer_if #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned INSTR_WIDTH  = 8,
    parameter int unsigned OPCODE_WIDTH = 3
);
    logic                                start;
    logic                                stall;
    logic [INSTR_WIDTH-1:0]              instrData;
    logic [ADDR_WIDTH-1:0]               instrAddress;
    logic                                instrReadEnable;
    logic [OPCODE_WIDTH-1:0]             opCode;
    logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand;
    logic                                instrValid;
    logic                                halted;
    logic [ADDR_WIDTH-1:0]               programCounter;

    modport master (
        input  start, stall, instrData,
        output instrAddress, instrReadEnable, opCode, operand, instrValid, halted,
               programCounter
    );

    modport slave (
        output start, stall, instrData,
        input  instrAddress, instrReadEnable, opCode, operand, instrValid, halted,
               programCounter
    );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Fetches words from a synchronous instruction ROM, splits them into opcode and
//   operand, and issues them one at a time to the control unit with a valid/stall
//   handshake. Stops permanently once a Halt opcode (all ones) is accepted.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     bus    instruction_sequencer_if.master (ROM and control-unit signals)
module instruction_sequencer #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned INSTR_WIDTH  = 8,
    parameter int unsigned OPCODE_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_sequencer_if.master bus
);
    localparam int unsigned OperandWidth = INSTR_WIDTH - OPCODE_WIDTH;
    localparam logic [OPCODE_WIDTH-1:0] HaltOp = {OPCODE_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StHalted
    } state_e;

    state_e                  stateQ, stateD;
    logic [ADDR_WIDTH-1:0]   pcQ, pcD;
    logic [OPCODE_WIDTH-1:0] opCodeQ, opCodeD;
    logic [OperandWidth-1:0] operandQ, operandD;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            pcQ      <= '0;
            opCodeQ  <= '0;
            operandQ <= '0;
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            opCodeQ  <= opCodeD;
            operandQ <= operandD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        opCodeD  = opCodeQ;
        operandD = operandQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.start) begin
                    stateD = StFetch;
                end
            end
            StFetch: begin
                stateD = StDecode;
            end
            StDecode: begin
                // ROM data returned for the address strobed in FETCH.
                opCodeD  = bus.instrData[INSTR_WIDTH-1 -: OPCODE_WIDTH];
                operandD = bus.instrData[OperandWidth-1:0];
                pcD      = pcQ + 1'b1;
                stateD   = StIssue;
            end
            StIssue: begin
                if (!bus.stall) begin
                    stateD = (opCodeQ == HaltOp) ? StHalted : StFetch;
                end
            end
            StHalted: begin
                stateD = StHalted;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Strobes decode straight from the registered state, so they are glitch-free
    // Moore outputs and follow reset automatically.
    assign bus.instrAddress    = pcQ;
    assign bus.programCounter  = pcQ;
    assign bus.instrReadEnable = (stateQ == StFetch);
    assign bus.instrValid      = (stateQ == StIssue);
    assign bus.halted          = (stateQ == StHalted);
    assign bus.opCode          = opCodeQ;
    assign bus.operand         = operandQ;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
//   Drives the sequencer against a behavioural ROM and checks every issued
//   instruction against the program stream computed from ROM contents.
module tb_instruction_sequencer;
    localparam int AW = 5;
    localparam int IW = 8;
    localparam int OW = 3;
    localparam int NW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_sequencer_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .OPCODE_WIDTH(OW)) bus ();

    instruction_sequencer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .OPCODE_WIDTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom [NW];
    logic [7:0] romData;
    always @(posedge clk) begin
        if (bus.instrReadEnable) romData <= rom[bus.instrAddress];
    end
    assign bus.instrData = romData;

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        tick();
        reset = 1'b0;
        checkEq("rst_pc", bus.programCounter, 0);
        checkEq("rst_opcode", bus.opCode, 0);
        checkEq("rst_operand", bus.operand, 0);
        checkEq("rst_valid", bus.instrValid, 0);
        checkEq("rst_re", bus.instrReadEnable, 0);
        checkEq("rst_halted", bus.halted, 0);
    endtask

    // Starts execution from startPc and follows the program: each instruction is
    // fetch, decode, issue (+ stall cycles). stallSel < 0 picks random stalls.
    // Returns with the DUT in FETCH after maxInstr acceptances, or after Halt.
    task automatic runProg(input int startPc, input int maxInstr, input int stallSel,
                           input bit poke, output int issued);
        int pc;
        int nStall;
        logic [7:0] w;
        pc     = startPc;
        issued = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (1) begin
            checkEq("fetch_re", bus.instrReadEnable, 1);
            checkEq("fetch_addr", bus.instrAddress, pc);
            checkEq("fetch_pc", bus.programCounter, pc);
            checkEq("fetch_valid", bus.instrValid, 0);
            if (issued >= maxInstr) break;
            tick();
            checkEq("dec_re", bus.instrReadEnable, 0);
            checkEq("dec_valid", bus.instrValid, 0);
            tick();
            w  = rom[pc];
            pc = (pc + 1) % NW;
            checkEq("iss_valid", bus.instrValid, 1);
            checkEq("iss_opcode", bus.opCode, w[7:5]);
            checkEq("iss_operand", bus.operand, w[4:0]);
            checkEq("iss_pc", bus.programCounter, pc);
            checkEq("iss_halted", bus.halted, 0);
            nStall = (stallSel < 0) ? int'($urandom_range(0, 3)) : stallSel;
            for (int i = 0; i < nStall; i++) begin
                bus.stall = 1'b1;
                bus.start = poke & 1'($urandom_range(0, 1));
                tick();
                checkEq("stall_valid", bus.instrValid, 1);
                checkEq("stall_opcode", bus.opCode, w[7:5]);
                checkEq("stall_operand", bus.operand, w[4:0]);
                checkEq("stall_pc", bus.programCounter, pc);
                checkEq("stall_re", bus.instrReadEnable, 0);
                checkEq("stall_halted", bus.halted, 0);
            end
            bus.stall = 1'b0;
            bus.start = 1'b0;
            tick();
            issued++;
            if (w[7:5] == 3'b111) begin
                for (int i = 0; i < 4; i++) begin
                    checkEq("halt_halted", bus.halted, 1);
                    checkEq("halt_valid", bus.instrValid, 0);
                    checkEq("halt_re", bus.instrReadEnable, 0);
                    checkEq("halt_pc", bus.programCounter, pc);
                    checkEq("halt_opcode", bus.opCode, w[7:5]);
                    checkEq("halt_operand", bus.operand, w[4:0]);
                    bus.start = poke & (i < 2);
                    tick();
                end
                bus.start = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int h;
        logic [7:0] w;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        for (int i = 0; i < NW; i++) rom[i] = 8'h00;

        // Two-instruction program ending in Halt, no stall.
        rom[0] = 8'h25;
        rom[1] = 8'hE0;
        doReset();
        runProg(0, 64, 0, 1, n);
        checkEq("t1_count", n, 2);

        // Long stall on the first instruction.
        rom[0] = 8'h6A;
        doReset();
        runProg(0, 64, 4, 1, n);
        checkEq("t2_count", n, 2);

        // 32 NOPs: counter wraps, 33rd fetch is at address 0.
        for (int i = 0; i < NW; i++) rom[i] = 8'h00;
        doReset();
        runProg(0, 32, -1, 0, n);
        checkEq("t3_count", n, 32);

        // Reset during DECODE discards the fetch; restart from address 0.
        for (int i = 0; i < NW; i++) begin
            w = 8'($urandom);
            if (w[7:5] == 3'b111) w[7] = 1'b0;
            rom[i] = w;
        end
        doReset();
        runProg(0, 2, 0, 0, n);
        tick();
        doReset();
        for (int i = 0; i < 4; i++) begin
            checkEq("idle_valid", bus.instrValid, 0);
            checkEq("idle_re", bus.instrReadEnable, 0);
            tick();
        end
        runProg(0, 3, -1, 0, n);
        checkEq("t4_count", n, 3);

        // Halt held under stall for 3 cycles.
        rom[0] = 8'hE3;
        doReset();
        runProg(0, 64, 3, 1, n);
        checkEq("t5_count", n, 1);

        // Random programs with random stalls and stray start pulses.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) rom[i] = 8'($urandom);
            h = int'($urandom_range(3, 12));
            w = 8'($urandom);
            w[7:5] = 3'b111;
            rom[h] = w;
            doReset();
            runProg(0, 64, -1, 1, n);
        end

        doReset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Producer side of the processor's opcode interface: fetches instruction words from a synchronous instruction ROM, splits each word into opcode and operand, and issues them one at a time to the control unit with a valid/stall handshake.
- Owns the program counter and stops permanently on the Halt opcode (3'b111).
- Sits between the instruction memory and the control unit / datapath.

Parameters:
- ADDR_WIDTH, 5: program counter and ROM address width.
- INSTR_WIDTH, 8: instruction word width.
- OPCODE_WIDTH, 3: opcode field width; opcode occupies bits [INSTR_WIDTH-1 -: OPCODE_WIDTH].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begins execution from the current program counter; honoured only in IDLE.
- stall  input  1  consumer back-pressure; an issued instruction is accepted only when instrValid=1 and stall=0.
- instrData  input  INSTR_WIDTH  ROM read data; valid the cycle after instrReadEnable.
- instrAddress  output  ADDR_WIDTH  ROM read address; equals programCounter.
- instrReadEnable  output  1  ROM read strobe.
- opCode  output  OPCODE_WIDTH  issued opcode; drives the control unit.
- operand  output  INSTR_WIDTH-OPCODE_WIDTH  issued operand, taken from the low bits of the instruction word.
- instrValid  output  1  opCode and operand hold an unaccepted instruction.
- halted  output  1  Halt has been accepted; sequencer is stopped.
- programCounter  output  ADDR_WIDTH  address of the next instruction to fetch.

Behaviour:
- Reset values: state IDLE, programCounter 0, opCode 0, operand 0, instrValid 0, instrReadEnable 0, halted 0. Reset has priority over every other input in every state.
- FSM states are IDLE, FETCH, DECODE, ISSUE and HALTED.
- IDLE: all strobes low. If start=1 at an edge, the next state is FETCH.
- FETCH (1 cycle): instrReadEnable=1, instrAddress=programCounter. The next state is DECODE.
- DECODE (1 cycle): instrReadEnable=0 and instrData is valid. At the closing edge:
  - opCode and operand are registered from instrData;
  - programCounter increments by 1, modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0);
  - the next state is ISSUE.
- ISSUE: instrValid=1, and opCode and operand are held stable for as long as stall=1. At an edge with stall=0 the instruction is accepted:
  - if opCode==3'b111, the next state is HALTED;
  - otherwise the next state is FETCH.
  - instrValid drops in the cycle after acceptance.
- HALTED: halted=1 and instrValid=0. No ROM reads occur. opCode, operand and programCounter keep their last values. Only reset leaves this state.
- Latency: start at edge k gives instrValid=1 from cycle k+3. With no stall, one instruction is issued every 3 cycles.
- The sequencer issues all opcodes (including NOP 3'b000) unmodified and does not interpret them, except for detecting Halt.
- start is ignored outside IDLE, including in HALTED. stall is ignored outside ISSUE.
- Halt under stall: halted stays 0 until the Halt instruction is accepted; it goes high the cycle after acceptance.
- Reset mid-operation (FETCH, DECODE, ISSUE or HALTED): the block returns to the reset values at the next edge. Any partially fetched instruction is discarded, and a new start is required.

Test Plan:
- ROM[0]=8'h25, ROM[1]=8'hE0; reset, then pulse start with stall=0.
  - Required: instrAddress=0 with readEnable=1, then opCode=3'b001 and operand=5'd5 with instrValid=1 for 1 cycle.
  - Then opCode=3'b111 and operand=0; halted=1 the following cycle and stays 1.
  - Required: programCounter=2, and no further instrReadEnable pulses.
- Hold stall=1 for 4 cycles while an instruction (ROM[0]=8'h6A) is in ISSUE.
  - Required: instrValid=1 with opCode=3'b011 and operand=5'd10 stable for 5 cycles.
  - Required: no ROM read until the cycle after stall falls.
- ROM filled with 32 NOPs (8'h00); start.
  - Required: after the 32nd acceptance, programCounter=0.
  - Required: the 33rd fetch is at instrAddress=0.
- Assert reset for 1 cycle during DECODE.
  - Required: the next cycle shows all outputs at reset values and the state is IDLE.
  - Required: no instrValid until a new start; execution then restarts at address 0.
- Pulse start while in ISSUE and while HALTED.
  - Required: no change in state, programCounter or outputs.
- Halt issued with stall=1 held for 3 cycles.
  - Required: halted=0 throughout the stall, and halted=1 exactly one cycle after stall drops.
